// File: rtl/dino_pkg.sv
`default_nettype none
// ============================================================================
// Module : dino_pkg
// Brief  : Shared types and constants for the obstacle spawner and renderers.
// Rev    : 1.0
// ============================================================================
package dino_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GAP    = 2'd1,
        PICK   = 2'd2,
        LAUNCH = 2'd3
    } spawn_state_t;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int COLNUM = 640;
    localparam int ROWNUM = 480;

endpackage
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
// ============================================================================
// Module : lfsr16
// Brief  : 16-bit Galois LFSR; a zero seed is replaced by 1 to avoid lock-up.
// Rev    : 1.0
// ============================================================================
module lfsr16
    import dino_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        step,
    output logic [15:0] value
);

    localparam logic [15:0] SEED_NZ = (SEED == 16'h0000) ? 16'h0001 : SEED;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= SEED_NZ;
        end else if (step) begin
            value <= (value >> 1) ^ (value[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule
`default_nettype wire

// File: rtl/obstacle_spawner.sv
`default_nettype none
// ============================================================================
// Module : obstacle_spawner
// Brief  : Scroll divider plus launch FSM that starts obstacle renderer lanes.
// Rev    : 1.0
// ============================================================================
module obstacle_spawner
    import dino_pkg::*;
#(
    parameter int          NUM_OBS       = 2,
    parameter int          CLK_DIV_INIT  = 250000,
    parameter int          CLK_DIV_MIN   = 100000,
    parameter int          SPEED_STEP    = 5000,
    parameter int          SPEEDUP_EVERY = 8,
    parameter int          GAP_MIN       = 200,
    parameter logic [7:0]  GAP_MASK      = 8'hFF,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               halt,
    input  logic [NUM_OBS-1:0] finish,
    output logic               scroll_tick,
    output logic [NUM_OBS-1:0] start,
    output logic               busy,
    output logic [15:0]        spawn_count,
    output logic [17:0]        period
);

    localparam int          LANE_W      = (NUM_OBS > 1) ? $clog2(NUM_OBS) : 1;
    localparam logic [17:0] PERIOD_INIT = 18'(CLK_DIV_INIT);
    localparam logic [17:0] PERIOD_MIN  = 18'(CLK_DIV_MIN);
    localparam logic [17:0] PERIOD_STEP = 18'(SPEED_STEP);
    localparam logic [17:0] PERIOD_SAT  = 18'(CLK_DIV_MIN + SPEED_STEP);
    localparam logic [15:0] SPEED_MOD   = 16'(SPEEDUP_EVERY);

    spawn_state_t        state;
    logic [17:0]         div_cnt;
    logic [15:0]         gap_cnt;
    logic [LANE_W-1:0]   lane;
    logic [NUM_OBS-1:0]  inflight;
    logic [NUM_OBS-1:0]  finish_q;
    logic [NUM_OBS-1:0]  lane_onehot;

    logic [15:0]         lfsr;
    logic [7:0]          lfsr_hi_unused;
    logic [15:0]         gap_load;
    logic [15:0]         spawn_next;
    logic [LANE_W-1:0]   pref;
    logic [LANE_W-1:0]   cand;
    logic [LANE_W-1:0]   pick_lane;
    logic                pick_found;
    logic                run;
    logic                tick_due;
    logic                speedup;

    lfsr16 #(
        .SEED  (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (1'b1),
        .value (lfsr)
    );

    assign lfsr_hi_unused = lfsr[15:8];

    assign run         = enable & ~halt;
    // >= rather than == so a freshly shortened period wraps on the next cycle.
    assign tick_due    = (div_cnt >= (period - 18'd1));
    assign scroll_tick = run & tick_due;

    assign gap_load    = 16'(GAP_MIN) + {8'h00, lfsr[7:0] & GAP_MASK};
    assign spawn_next  = spawn_count + 16'd1;
    assign speedup     = ((spawn_next % SPEED_MOD) == 16'd0);

    assign lane_onehot = {{(NUM_OBS-1){1'b0}}, 1'b1} << lane;
    assign start       = ((state == LAUNCH) && run) ? lane_onehot : '0;
    assign busy        = |inflight;

    assign pref = LANE_W'(int'(lfsr[1:0]) % NUM_OBS);

    // Round-robin search starting at the random preferred lane.
    always_comb begin
        pick_found = 1'b0;
        pick_lane  = '0;
        cand       = '0;
        for (int k = 0; k < NUM_OBS; k++) begin
            cand = LANE_W'((int'(pref) + k) % NUM_OBS);
            if (!pick_found && !inflight[cand]) begin
                pick_found = 1'b1;
                pick_lane  = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (!enable) begin
            div_cnt <= '0;
        end else if (!halt) begin
            div_cnt <= tick_due ? 18'd0 : div_cnt + 18'd1;
        end
    end

    // Lane tracking keeps running under halt and with enable low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            finish_q <= '1;
            inflight <= '0;
        end else begin
            finish_q <= finish;
            inflight <= (inflight & ~(finish & ~finish_q)) | start;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            gap_cnt     <= '0;
            lane        <= '0;
            spawn_count <= '0;
            period      <= PERIOD_INIT;
        end else if (!enable) begin
            state <= IDLE;
        end else if (!halt) begin
            case (state)
                IDLE: begin
                    period      <= PERIOD_INIT;
                    spawn_count <= '0;
                    gap_cnt     <= gap_load;
                    state       <= GAP;
                end
                GAP: begin
                    if (scroll_tick) begin
                        if (gap_cnt <= 16'd1) begin
                            state <= PICK;
                        end else begin
                            gap_cnt <= gap_cnt - 16'd1;
                        end
                    end
                end
                PICK: begin
                    if (pick_found) begin
                        lane  <= pick_lane;
                        state <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    spawn_count <= spawn_next;
                    if (speedup) begin
                        period <= (period >= PERIOD_SAT) ? (period - PERIOD_STEP) : PERIOD_MIN;
                    end
                    gap_cnt <= gap_load;
                    state   <= GAP;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
